// File: rtl/cache_pkg.sv
// Shared state encoding and address-field geometry for the cache miss controller and cache array.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WBCHK,
        WB,
        REFILL,
        RESP
    } state_t;

    localparam int ADDR_W   = 32;
    localparam int TAG_W    = 18;
    localparam int SET_W    = 8;
    localparam int OFFSET_W = 6;
    localparam int SET_LSB  = OFFSET_W;
    localparam int TAG_LSB  = OFFSET_W + SET_W;

endpackage

// File: rtl/cache_perf_counters.sv
// Three saturating event counters (hit, miss, writeback); used only when CACHE_PERF_CNT_EN is defined.
module cache_perf_counters #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hit_inc,
    input  logic                 miss_inc,
    input  logic                 wb_inc,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic [CNT_WIDTH-1:0] wb_cnt
);

    logic [2:0]           inc;
    logic [CNT_WIDTH-1:0] cnt_reg [3];

    assign inc = {wb_inc, miss_inc, hit_inc};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (inc[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign hit_cnt  = cnt_reg[0];
    assign miss_cnt = cnt_reg[1];
    assign wb_cnt   = cnt_reg[2];

endmodule

// File: rtl/cache_miss_ctrl.sv
// CPU/cache/memory sequencer: lookup, dirty-victim writeback, refill and replay.
// Optional perf counters are enabled with the CACHE_PERF_CNT_EN macro.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = TAG_W,
    parameter int SET_WIDTH     = SET_W,
    parameter int OFFSET_WIDTH  = OFFSET_W,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_busy,
    output logic                     cpu_done,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     c_write_en,
    output logic                     c_write_en_main_mem,
    output logic [ADDRESS_WIDTH-1:0] c_mem_add,
    output logic [DATA_WIDTH-1:0]    c_data_in,
    input  logic                     c_data_ready,
    input  logic [DATA_WIDTH-1:0]    c_data_out,
    input  logic                     c_wb_valid,
    input  logic [TAG_WIDTH-1:0]     c_wb_tag,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     hit_cnt,
    output logic [CNT_WIDTH-1:0]     miss_cnt,
    output logic [CNT_WIDTH-1:0]     wb_cnt
`endif
);

    state_t                   state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0]    wdata_reg;
    logic                     we_reg;
    logic [TAG_WIDTH-1:0]     wb_tag_reg;
    logic                     first_pass_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            we_reg         <= 1'b0;
            wb_tag_reg     <= '0;
            first_pass_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && cpu_req) begin
                addr_reg       <= cpu_addr;
                wdata_reg      <= cpu_wdata;
                we_reg         <= cpu_we;
                first_pass_reg <= 1'b1;
            end
            if (state_reg == WBCHK && c_wb_valid) begin
                wb_tag_reg <= c_wb_tag;
            end
            // The post-refill lookup is a replay and must not count as a hit.
            if (state_reg == REFILL && mem_ack) begin
                first_pass_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next          = state_reg;
        c_write_en          = 1'b0;
        c_write_en_main_mem = 1'b0;
        mem_req             = 1'b0;
        mem_we              = 1'b0;
        mem_addr            = '0;
        cpu_done            = 1'b0;
        cpu_rdata           = '0;
        case (state_reg)
            IDLE: begin
                if (cpu_req) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (we_reg) begin
                    c_write_en = 1'b1;
                    state_next = WBCHK;
                end else if (c_data_ready) begin
                    state_next = RESP;
                end else begin
                    state_next = WBCHK;
                end
            end
            WBCHK: begin
                if (c_wb_valid) state_next = WB;
                else if (we_reg) state_next = RESP;
                else state_next = REFILL;
            end
            WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {wb_tag_reg, addr_reg[OFFSET_WIDTH +: SET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                if (mem_ack) state_next = we_reg ? RESP : REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {addr_reg[ADDRESS_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                if (mem_ack) begin
                    c_write_en_main_mem = 1'b1;
                    state_next          = LOOKUP;
                end
            end
            RESP: begin
                cpu_done   = 1'b1;
                cpu_rdata  = we_reg ? '0 : c_data_out;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cpu_busy  = (state_reg != IDLE);
    assign c_mem_add = addr_reg;
    assign c_data_in = wdata_reg;

`ifdef CACHE_PERF_CNT_EN
    cache_perf_counters #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf (
        .clk      (clk),
        .reset    (reset),
        .hit_inc  (state_reg == LOOKUP && first_pass_reg && c_data_ready),
        .miss_inc (state_reg == LOOKUP && first_pass_reg && !we_reg && !c_data_ready),
        .wb_inc   (state_reg == WB && mem_ack),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
        .wb_cnt   (wb_cnt)
    );
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: behavioural cache/memory models, queued expectations.
module tb_cache_miss_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 18;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_busy, cpu_done;
    logic [DW-1:0] cpu_rdata;
    logic          c_write_en, c_write_en_main_mem;
    logic [AW-1:0] c_mem_add;
    logic [DW-1:0] c_data_in;
    logic          c_data_ready;
    logic [DW-1:0] c_data_out = '0;
    logic          c_wb_valid = 1'b0;
    logic [TW-1:0] c_wb_tag = '0;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
`ifdef CACHE_PERF_CNT_EN
    logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    cache_miss_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .c_write_en(c_write_en), .c_write_en_main_mem(c_write_en_main_mem),
        .c_mem_add(c_mem_add), .c_data_in(c_data_in),
        .c_data_ready(c_data_ready), .c_data_out(c_data_out),
        .c_wb_valid(c_wb_valid), .c_wb_tag(c_wb_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack)
`ifdef CACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] rdata; int lat; } resp_t;
    typedef struct { logic we; logic [AW-1:0] addr; } memx_t;

    resp_t         resp_q[$];
    memx_t         mem_q[$];
    int            n_tests = 0, n_fail = 0;
    int            cyc = 0, accept_cyc = 0;
    int            done_cnt = 0, wb_cnt_tb = 0, fill_cnt_tb = 0, cwe_cnt = 0;
    logic          hit_flag = 1'b0, mem_auto = 1'b1, tracking = 1'b0;
    logic [DW-1:0] cache_word = '0;
    logic [AW-1:0] cur_addr = '0;

    assign c_data_ready = hit_flag;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        c_data_out <= hit_flag ? cache_word : '0;
    end

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Response monitor and per-cycle invariants.
    initial forever begin
        @(negedge clk);
        if (c_write_en && c_write_en_main_mem) check("we_exclusive", 1, 0);
        if (c_write_en) cwe_cnt++;
        if (tracking && cpu_busy) check("c_mem_add_hold", c_mem_add, cur_addr);
        if (cpu_done) begin
            if (resp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                check("cpu_rdata", cpu_rdata, r.rdata);
                if (r.lat != 0) check("latency", cyc - accept_cyc + 1, r.lat);
            end
            done_cnt++;
        end
    end

    // Memory responder: acks each request two cycles after it is first seen.
    initial forever begin
        @(negedge clk);
        if (mem_auto && mem_req) begin
            logic is_fill;
            if (mem_q.size() == 0) begin
                check("unexpected_mem_req", 1, 0);
            end else begin
                memx_t m;
                m = mem_q.pop_front();
                check("mem_we", {31'b0, mem_we}, {31'b0, m.we});
                check("mem_addr", mem_addr, m.addr);
            end
            repeat (2) @(negedge clk);
            mem_ack = 1'b1;
            is_fill = !mem_we;
            #1;
            if (is_fill) begin
                check("c_write_en_main_mem", {31'b0, c_write_en_main_mem}, 32'd1);
                fill_cnt_tb++;
            end else begin
                wb_cnt_tb++;
            end
            @(posedge clk);
            #1;
            if (is_fill) hit_flag = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
        end
    end

    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic hit, input logic dirty, input logic [TW-1:0] wbtag,
                          input logic [DW-1:0] word, input int lat);
        int start, cw0;
        resp_t r;
        @(negedge clk);
        hit_flag   = hit;
        c_wb_valid = dirty;
        c_wb_tag   = wbtag;
        cache_word = word;
        cur_addr   = addr;
        r.rdata    = we ? '0 : word;
        r.lat      = lat;
        resp_q.push_back(r);
        start      = done_cnt;
        cw0        = cwe_cnt;
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        accept_cyc = cyc;
        @(negedge clk);
        cpu_req  = 1'b0;
        tracking = 1'b1;
        for (int i = 0; i < 60 && done_cnt == start; i++) @(negedge clk);
        if (done_cnt == start) check("done_timeout", 0, 1);
        check("c_write_en_pulses", cwe_cnt - cw0, we ? 1 : 0);
        @(negedge clk);
        tracking   = 1'b0;
        check("idle_after_done", {31'b0, cpu_busy}, 32'd0);
        hit_flag   = 1'b0;
        c_wb_valid = 1'b0;
    endtask

    initial begin
        int wb0, f0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, cpu_busy}, 0);
        check("rst_done", {31'b0, cpu_done}, 0);
        check("rst_mem_req", {31'b0, mem_req}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_c_mem_add", c_mem_add, 0);
        check("rst_rdata", cpu_rdata, 0);
        reset = 1'b0;

        // Hits: two loads and one store, no memory traffic.
        wb0 = wb_cnt_tb; f0 = fill_cnt_tb;
        do_req(1'b0, 32'h0000_1040, '0, 1'b1, 1'b0, '0, 32'hDEAD_BEEF, 3);
        do_req(1'b0, 32'h0000_2044, '0, 1'b1, 1'b0, '0, 32'h0BAD_F00D, 3);
        do_req(1'b1, 32'h0000_2000, 32'h5555_AAAA, 1'b1, 1'b0, '0, '0, 4);
        check("hit_no_mem", (wb_cnt_tb - wb0) + (fill_cnt_tb - f0), 0);
        check("store_c_data_in", c_data_in, 32'h5555_AAAA);

        // Clean load miss.
        mem_q.push_back('{1'b0, 32'h0004_0080});
        do_req(1'b0, 32'h0004_0080, '0, 1'b0, 1'b0, '0, 32'h1234_5678, 0);

        // Load miss with dirty victim: writeback then refill.
        mem_q.push_back('{1'b1, 32'h0000_C080});
        mem_q.push_back('{1'b0, 32'h0008_0080});
        do_req(1'b0, 32'h0008_0084, '0, 1'b0, 1'b1, 18'h3, 32'hCAFE_F00D, 0);

`ifdef CACHE_PERF_CNT_EN
        check("hit_cnt", {30'b0, hit_cnt}, 3);
        check("miss_cnt", {30'b0, miss_cnt}, 2);
        check("wb_cnt", {30'b0, wb_cnt}, 1);
`endif

        // Store to a full set: exactly one writeback, no refill.
        wb0 = wb_cnt_tb; f0 = fill_cnt_tb;
        mem_q.push_back('{1'b1, 32'h0001_C100});
        do_req(1'b1, 32'h0010_0104, 32'h0000_0077, 1'b0, 1'b1, 18'h7, '0, 0);
        check("store_wb_count", wb_cnt_tb - wb0, 1);
        check("store_no_fill", fill_cnt_tb - f0, 0);

`ifdef CACHE_PERF_CNT_EN
        do_req(1'b0, 32'h0000_1040, '0, 1'b1, 1'b0, '0, 32'h0000_0001, 3);
        check("hit_cnt_sat", {30'b0, hit_cnt}, 3);
`endif

        // Reset asserted mid-refill; a late ack must be ignored.
        mem_auto = 1'b0;
        @(negedge clk);
        hit_flag = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0005_0010;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check("t5_mem_req", {31'b0, mem_req}, 1);
        check("t5_mem_addr", mem_addr, 32'h0005_0000);
        check("t5_mem_we", {31'b0, mem_we}, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_req_dropped", {31'b0, mem_req}, 0);
        check("t5_idle", {31'b0, cpu_busy}, 0);
        check("t5_c_mem_add", c_mem_add, 0);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("t5_ack_ignored_busy", {31'b0, cpu_busy}, 0);
        check("t5_ack_ignored_fill", {31'b0, c_write_en_main_mem}, 0);
        repeat (2) @(negedge clk);
        check("t5_still_idle", {31'b0, cpu_busy | cpu_done}, 0);

        check("resp_q_empty", resp_q.size(), 0);
        check("mem_q_empty", mem_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
